// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: start/redirect control, instruction-memory port and decode-side IR handshake.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [ADDR_W-1:0] ir_pc;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              halted;

  modport master (
    input  start, mem_gnt, mem_rvalid, mem_rdata, ir_ready, br_valid, br_target,
    output mem_req, mem_addr, ir, ir_valid, ir_pc, halted
  );

  modport slave (
    output start, mem_gnt, mem_rvalid, mem_rdata, ir_ready, br_valid, br_target,
    input  mem_req, mem_addr, ir, ir_valid, ir_pc, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM with redirect and halt-word detection.
// Define FETCH_SEQUENCER_PERF_EN to add fetch/stall performance counters.
module fetch_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] fetch_addr_reg, fetch_addr_next;
  logic [31:0]       ir_reg, ir_next;
  logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
  logic              drop_reg, drop_next;
  logic              issue;
  logic              accepted;

  // While a discarded response is still in flight, REQ must not issue a second request.
  assign issue    = (state_reg == S_REQ) && !drop_reg;
  assign accepted = issue && bus.mem_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      pc_reg         <= RESET_PC;
      fetch_addr_reg <= '0;
      ir_reg         <= 32'h0;
      ir_pc_reg      <= '0;
      drop_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      fetch_addr_reg <= fetch_addr_next;
      ir_reg         <= ir_next;
      ir_pc_reg      <= ir_pc_next;
      drop_reg       <= drop_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    fetch_addr_next = fetch_addr_reg;
    ir_next         = ir_reg;
    ir_pc_next      = ir_pc_reg;
    drop_next       = drop_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.br_valid) pc_next = bus.br_target;
        if (bus.start) state_next = S_REQ;
      end
      S_REQ: begin
        if (drop_reg && bus.mem_rvalid) drop_next = 1'b0;
        if (bus.br_valid) begin
          pc_next = bus.br_target;
          // A grant coinciding with a redirect still returns data; mark it for discard.
          if (accepted) drop_next = 1'b1;
        end else if (accepted) begin
          pc_next         = ADDR_W'(pc_reg + 1'b1);
          fetch_addr_next = pc_reg;
          state_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.br_valid) pc_next = bus.br_target;
        if (bus.mem_rvalid) begin
          drop_next = 1'b0;
          if (bus.br_valid || drop_reg) begin
            state_next = S_REQ;
          end else begin
            ir_next    = bus.mem_rdata;
            ir_pc_next = fetch_addr_reg;
            state_next = S_HOLD;
          end
        end else if (bus.br_valid) begin
          drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.br_valid) begin
          pc_next    = bus.br_target;
          state_next = S_REQ;
        end else if (bus.ir_ready) begin
          state_next = (ir_reg == HALT_WORD) ? S_HALT : S_REQ;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req  = issue;
    bus.mem_addr = pc_reg;
    bus.ir       = ir_reg;
    bus.ir_pc    = ir_pc_reg;
    bus.ir_valid = (state_reg == S_HOLD);
    bus.halted   = (state_reg == S_HALT);
  end

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_reg <= 32'h0;
      stall_cnt_reg <= 32'h0;
    end else if (state_reg == S_HOLD) begin
      if (bus.ir_ready) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      else              stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch order, stall, redirects, PC wrap, reset mid-fetch, halt.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(8)) mif ();

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (mif.master)
`ifdef FETCH_SEQUENCER_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cd = 0;
  logic [7:0] pend_addr = 8'h00;
  bit halt_en = 1'b0;
  logic [7:0] halt_addr = 8'h03;

  function automatic logic [31:0] resp(input logic [7:0] a);
    if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
    return 32'h1111_0000 + {24'h0, a};
  endfunction

  // One clock; memory model answers each grant after 'lat' cycles.
  task automatic tick();
    logic g;
    logic [7:0] ga;
    g  = mif.mem_req && mif.mem_gnt;
    ga = mif.mem_addr;
    @(posedge clk); #1;
    mif.start    = 1'b0;
    mif.br_valid = 1'b0;
    if (g) begin
      cd = lat;
      pend_addr = ga;
    end else if (cd > 0) begin
      cd--;
    end
    mif.mem_rvalid = (cd == 1);
    mif.mem_rdata  = (cd == 1) ? resp(pend_addr) : 32'h0;
  endtask

  task automatic wait_ir(output int n);
    n = 0;
    while (mif.ir_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mif.ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_ir_timeout: ir_valid=%b after %0d cycles, want 1", mif.ir_valid, n);
    end else begin
      $display("fetch ir_pc=%h ir=%h after %0d cycles", mif.ir_pc, mif.ir, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mif.start = 0; mif.mem_gnt = 1; mif.mem_rvalid = 0; mif.mem_rdata = 0;
    mif.ir_ready = 0; mif.br_valid = 0; mif.br_target = 0;
    tick();
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mif.mem_req); end
    checks++; if (mif.ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", mif.ir); end
    checks++; if (mif.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %b want 0", mif.ir_valid); end
    checks++; if (mif.ir_pc !== 8'h00) begin errors++; $display("FAIL reset_ir_pc: got %h want 00", mif.ir_pc); end
    checks++; if (mif.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", mif.halted); end
    reset = 1'b0;
    tick();
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b want 0", mif.mem_req); end
    $display("reset done");
  endtask

  task automatic test_basic_fetch();
    int n;
    lat = 1; mif.ir_ready = 1'b1;
    mif.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      wait_ir(n);
      checks++; if (n !== ((k == 0) ? 3 : 2)) begin errors++; $display("FAIL basic_latency_%0d: got %0d want %0d", k, n, (k == 0) ? 3 : 2); end
      checks++; if (mif.ir !== 32'h1111_0000 + k) begin errors++; $display("FAIL basic_ir_%0d: got %h want %h", k, mif.ir, 32'h1111_0000 + k); end
      checks++; if (mif.ir_pc !== 8'(k)) begin errors++; $display("FAIL basic_ir_pc_%0d: got %h want %h", k, mif.ir_pc, 8'(k)); end
    end
  endtask

  task automatic test_hold_stall();
    mif.ir_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (mif.ir !== 32'h1111_0002 || mif.ir_pc !== 8'h02 || mif.ir_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold_%0d: ir=%h ir_pc=%h v=%b want 11110002/02/1", k, mif.ir, mif.ir_pc, mif.ir_valid); end
      checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL stall_mem_req_%0d: got %b want 0", k, mif.mem_req); end
    end
`ifdef FETCH_SEQUENCER_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d want 5", perf_stall_cnt); end
    checks++; if (perf_fetch_cnt !== 32'd2) begin errors++; $display("FAIL perf_fetch: got %0d want 2", perf_fetch_cnt); end
`endif
    mif.ir_ready = 1'b1;
    tick();
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 8'h03) begin errors++; $display("FAIL stall_release: req=%b addr=%h want 1/03", mif.mem_req, mif.mem_addr); end
    $display("stall done");
  endtask

  task automatic test_branch_wait();
    int n;
    lat = 2; mif.ir_ready = 1'b0;
    tick();
    mif.br_valid = 1'b1; mif.br_target = 8'h40;
    tick();
    checks++; if (mif.mem_req !== 1'b0 || mif.ir_valid !== 1'b0) begin errors++; $display("FAIL brw_drop_cycle: req=%b v=%b want 0/0", mif.mem_req, mif.ir_valid); end
    tick();
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 8'h40) begin errors++; $display("FAIL brw_redirect: req=%b addr=%h want 1/40", mif.mem_req, mif.mem_addr); end
    checks++; if (mif.ir !== 32'h1111_0002 || mif.ir_valid !== 1'b0) begin errors++; $display("FAIL brw_ir_kept: ir=%h v=%b want 11110002/0", mif.ir, mif.ir_valid); end
    wait_ir(n);
    checks++; if (mif.ir !== 32'h1111_0040 || mif.ir_pc !== 8'h40) begin errors++; $display("FAIL brw_ir: ir=%h pc=%h want 11110040/40", mif.ir, mif.ir_pc); end
  endtask

  task automatic test_wrap();
    int n;
    lat = 1;
    mif.br_valid = 1'b1; mif.br_target = 8'hFF;
    tick();
    checks++; if (mif.ir_valid !== 1'b0 || mif.mem_req !== 1'b1 || mif.mem_addr !== 8'hFF)
      begin errors++; $display("FAIL brh_redirect: v=%b req=%b addr=%h want 0/1/ff", mif.ir_valid, mif.mem_req, mif.mem_addr); end
    mif.ir_ready = 1'b1;
    wait_ir(n);
    checks++; if (mif.ir !== 32'h1111_00FF || mif.ir_pc !== 8'hFF) begin errors++; $display("FAIL wrap_ir: ir=%h pc=%h want 111100ff/ff", mif.ir, mif.ir_pc); end
    tick();
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: req=%b addr=%h want 1/00", mif.mem_req, mif.mem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    lat = 3;
    tick();
    reset = 1'b1; #1;
    checks++; if (mif.ir !== 32'h0 || mif.ir_valid !== 1'b0 || mif.mem_req !== 1'b0)
      begin errors++; $display("FAIL rstw_async: ir=%h v=%b req=%b want 0/0/0", mif.ir, mif.ir_valid, mif.mem_req); end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (mif.ir !== 32'h0 || mif.ir_valid !== 1'b0 || mif.mem_req !== 1'b0)
      begin errors++; $display("FAIL rstw_stale_rvalid: ir=%h v=%b req=%b want 0/0/0", mif.ir, mif.ir_valid, mif.mem_req); end
    lat = 1;
    mif.start = 1'b1;
    tick();
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 8'h00) begin errors++; $display("FAIL rstw_pc: req=%b addr=%h want 1/00", mif.mem_req, mif.mem_addr); end
  endtask

  task automatic test_branch_req();
    int n;
    mif.br_valid = 1'b1; mif.br_target = 8'h20;
    tick();
    wait_ir(n);
    checks++; if (mif.ir !== 32'h1111_0020 || mif.ir_pc !== 8'h20) begin errors++; $display("FAIL brr_ir: ir=%h pc=%h want 11110020/20", mif.ir, mif.ir_pc); end
  endtask

  task automatic test_halt();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 1; halt_en = 1'b1; mif.ir_ready = 1'b1;
    mif.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ir(n);
      checks++; if (mif.ir !== resp(8'(k)) || mif.ir_pc !== 8'(k)) begin errors++; $display("FAIL halt_seq_%0d: ir=%h pc=%h want %h/%h", k, mif.ir, mif.ir_pc, resp(8'(k)), 8'(k)); end
      tick();
    end
    checks++; if (mif.halted !== 1'b1 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: halted=%b req=%b want 1/0", mif.halted, mif.mem_req); end
    mif.start = 1'b1; mif.br_valid = 1'b1; mif.br_target = 8'h10;
    tick();
    tick();
    checks++; if (mif.halted !== 1'b1 || mif.mem_req !== 1'b0 || mif.ir_valid !== 1'b0)
      begin errors++; $display("FAIL halt_ignore: halted=%b req=%b v=%b want 1/0/0", mif.halted, mif.mem_req, mif.ir_valid); end
    checks++; if (mif.mem_addr !== 8'h04 || mif.ir_pc !== 8'h03) begin errors++; $display("FAIL halt_pc: addr=%h ir_pc=%h want 04/03", mif.mem_addr, mif.ir_pc); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_branch_wait();
    test_wrap();
    test_reset_mid_wait();
    test_branch_req();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
